// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg
//   Shared types and constants for the UART transmit serializer.
//   - state_t      : serializer FSM states
//   - WLS_*        : word-length select encodings (5..8 data bits)
//   - last_bit_idx : index of the final data bit for a given WLS code
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STARTBIT = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP1    = 3'd4,
    STOP2    = 3'd5
  } state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // The WLS code is the word length minus five, so the last bit index is 4 + code.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity
//   Combinational parity generator for a 5..8 bit word.
//   Ports:
//     data   [7:0] in  : word to protect; bits above the word length are ignored
//     wls    [1:0] in  : word-length code (00=5 .. 11=8)
//     eps          in  : 1 = even parity, 0 = odd parity
//     sp           in  : stick parity; forces the bit to ~eps
//     parity       out : parity bit to transmit
module uart_tx_parity
  import uart_tx_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] wls,
  input  logic       eps,
  input  logic       sp,
  output logic       parity
);

  logic [7:0] mask;
  logic       xor_all;

  // Keep only the bits that are actually transmitted for this word length.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
      localparam logic [2:0] IDX = 3'(gi);
      assign mask[gi] = (IDX <= last_bit_idx(wls));
    end
  endgenerate

  assign xor_all = ^(data & mask);

  // Even parity makes the total count of ones even, so the bit equals the XOR.
  assign parity = sp  ? ~eps :
                  eps ? xor_all : ~xor_all;

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   UART transmit serializer with oversampled bit timing.
//   Build option: define UART_TX_PARITY_EN to enable the parity bit; when it is
//   undefined PEN/EPS/SP are ignored and DATA goes straight to STOP1.
//   Parameters:
//     OVERSAMPLE : CE ticks per serial bit (even, >= 4)
//   Ports:
//     CLK        in  : system clock, rising edge
//     RST        in  : asynchronous active-high reset
//     CE         in  : oversample tick, one CLK wide
//     START      in  : frame request, accepted only when idle
//     DIN  [7:0] in  : data, LSB first
//     WLS  [1:0] in  : word length code (5..8 bits)
//     STB        in  : extra stop (1.5 for 5-bit words, else 2)
//     PEN        in  : parity enable
//     EPS        in  : even parity select
//     SP         in  : stick parity
//     BC         in  : break control, forces SOUT low
//     SOUT       out : registered serial line, idle high
//     TXFINISHED out : high while idle and ready for START
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       START,
  input  logic [7:0] DIN,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       BC,
  output logic       SOUT,
  output logic       TXFINISHED
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST      = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] tick_reg, tick_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    din_reg;
  logic [1:0]    wls_reg;
  logic          stb_reg, pen_reg, eps_reg, sp_reg;
  logic          sout_reg, sout_next;
  logic          capture;
  logic          par_bit;
  logic [TW-1:0] tick_end;

  uart_tx_parity u_parity (
    .data   (din_reg),
    .wls    (wls_reg),
    .eps    (eps_reg),
    .sp     (sp_reg),
    .parity (par_bit)
  );

`ifndef UART_TX_PARITY_EN
  // Captured for a uniform register set; has no effect in this build.
  logic unused_pen;
  assign unused_pen = pen_reg;
`endif

  // STOP2 is only reached with STB set; with a 5-bit word it is a half bit (1.5 stops).
  assign tick_end = (state_reg == STOP2 && wls_reg == WLS_5) ? TICK_HALF_LAST : TICK_LAST;

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    capture    = 1'b0;
    if (state_reg == IDLE) begin
      // START is honoured in IDLE regardless of CE.
      tick_next = '0;
      bit_next  = '0;
      if (START) begin
        capture    = 1'b1;
        state_next = STARTBIT;
      end
    end else if (CE) begin
      if (tick_reg == tick_end) begin
        tick_next = '0;
        case (state_reg)
          STARTBIT: state_next = DATA;
          DATA: begin
            if (bit_reg == last_bit_idx(wls_reg)) begin
              bit_next = '0;
`ifdef UART_TX_PARITY_EN
              state_next = pen_reg ? PARITY : STOP1;
`else
              state_next = STOP1;
`endif
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end
          PARITY:  state_next = STOP1;
          STOP1:   state_next = stb_reg ? STOP2 : IDLE;
          STOP2:   state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end else begin
        tick_next = tick_reg + TW'(1);
      end
    end
  end

  // Line level follows the current state one clock later; break overrides everything.
  always_comb begin
    sout_next = 1'b1;
    if (BC) begin
      sout_next = 1'b0;
    end else begin
      case (state_reg)
        STARTBIT: sout_next = 1'b0;
        DATA:     sout_next = din_reg[bit_reg];
        PARITY:   sout_next = par_bit;
        default:  sout_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      sout_reg  <= 1'b1;
      din_reg   <= '0;
      wls_reg   <= '0;
      stb_reg   <= 1'b0;
      pen_reg   <= 1'b0;
      eps_reg   <= 1'b0;
      sp_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      sout_reg  <= sout_next;
      if (capture) begin
        din_reg <= DIN;
        wls_reg <= WLS;
        stb_reg <= STB;
        pen_reg <= PEN;
        eps_reg <= EPS;
        sp_reg  <= SP;
      end
    end
  end

  assign SOUT       = sout_reg;
  assign TXFINISHED = (state_reg == IDLE);

endmodule
